// File: rtl/light_conflict_monitor.sv
// rtl/light_conflict_monitor.sv - lamp safety stage: re-drives lamp codes 2 cycles late,
// latches the first fault and flashes all approaches red until an operator clear.
module light_conflict_monitor #(
   parameter int MIN_YELLOW      = 30,
   parameter int CONFLICT_FILTER = 2,
   parameter int FLASH_HALF      = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] light_M1,
   input  logic [2:0] light_M2,
   input  logic [2:0] light_MT,
   input  logic [2:0] light_S,
   input  logic       clear_fault,
   output logic [2:0] out_M1,
   output logic [2:0] out_M2,
   output logic [2:0] out_MT,
   output logic [2:0] out_S,
   output logic       fault,
   output logic [2:0] fault_code,
   output logic [3:0] fault_src
);
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam int YW = $clog2(MIN_YELLOW + 1);
   localparam int FW = $clog2(CONFLICT_FILTER + 1);
   localparam int HW = $clog2(FLASH_HALF + 1);
   localparam logic [YW-1:0] Y_MAX  = YW'(MIN_YELLOW);
   localparam logic [FW-1:0] F_MAX  = FW'(CONFLICT_FILTER);
   localparam logic [HW-1:0] H_LAST = HW'(FLASH_HALF - 1);

   typedef enum logic {MONITOR, FAULT_FLASH} state_t;
   state_t state, state_nx;

   // Lamp slots [3..0] = M1, M2, MT, S, so every flag vector is already in fault_src order.
   logic [3:0][2:0]    samp, prev, drive, drive_nx;
   logic [3:0][YW-1:0] ycnt, ycnt_nx;
   logic [FW-1:0]      filt, filt_nx;
   logic [HW-1:0]      hcnt, hcnt_nx;
   logic               lit, lit_nx;
   logic               fault_nx, trip, leave;
   logic [2:0]         code_nx;
   logic [3:0]         src_nx;
   logic [3:0]         act, inv, skip, short_y, bad_seq, conf_src;
   logic               conflict, invalid, pending, all_red;

   for (genvar g = 0; g < 4; g++) begin : g_lamp
      assign act[g]     = (samp[g] == YEL) || (samp[g] == GRN);
      assign inv[g]     = !act[g] && (samp[g] != RED);
      assign skip[g]    = (prev[g] == GRN) && (samp[g] == RED);
      assign short_y[g] = (prev[g] == YEL) && (samp[g] == RED) && (ycnt[g] < Y_MAX);
      assign bad_seq[g] = ((prev[g] == RED) && (samp[g] == YEL)) ||
                          ((prev[g] == YEL) && (samp[g] == GRN));
      assign ycnt_nx[g] = (samp[g] != YEL) ? '0 :
                          (ycnt[g] == Y_MAX) ? ycnt[g] : ycnt[g] + 1'b1;
   end

   always_comb begin
      conf_src = '0;
      if (act[0] && (act[3] || act[2] || act[1])) conf_src = {act[3:1], 1'b1};
      if (act[2] && act[1]) conf_src = conf_src | 4'b0110;
   end

   assign conflict = |conf_src;
   assign invalid  = |inv;
   assign pending  = conflict || invalid;
   assign all_red  = (samp == {4{RED}});

   always_comb begin
      state_nx = state;
      drive_nx = drive;
      fault_nx = fault;
      code_nx  = fault_code;
      src_nx   = fault_src;
      filt_nx  = filt;
      hcnt_nx  = hcnt;
      lit_nx   = lit;
      trip     = 1'b0;
      leave    = 1'b0;
      case (state)
         MONITOR: begin
            filt_nx = !pending ? '0 : (filt == F_MAX) ? filt : filt + 1'b1;
            if (pending && (filt_nx == F_MAX)) begin
               trip    = 1'b1;
               code_nx = conflict ? 3'd2 : 3'd1;
               src_nx  = conflict ? conf_src : inv;
            end else if (|skip) begin
               trip = 1'b1; code_nx = 3'd3; src_nx = skip;
            end else if (|short_y) begin
               trip = 1'b1; code_nx = 3'd4; src_nx = short_y;
            end else if (|bad_seq) begin
               trip = 1'b1; code_nx = 3'd5; src_nx = bad_seq;
            end
            // A filtered conflict is held at red so it never reaches the lamps.
            if (trip) begin
               state_nx = FAULT_FLASH;
               fault_nx = 1'b1;
               drive_nx = {4{RED}};
               hcnt_nx  = '0;
               lit_nx   = 1'b1;
            end else if (pending) begin
               drive_nx = {4{RED}};
            end else begin
               drive_nx = samp;
            end
         end
         FAULT_FLASH: begin
            if (clear_fault && all_red) begin
               state_nx = MONITOR;
               fault_nx = 1'b0;
               code_nx  = '0;
               src_nx   = '0;
               drive_nx = {4{RED}};
               filt_nx  = '0;
               hcnt_nx  = '0;
               lit_nx   = 1'b0;
               leave    = 1'b1;
            end else begin
               if (hcnt == H_LAST) begin
                  hcnt_nx = '0;
                  lit_nx  = !lit;
               end else begin
                  hcnt_nx = hcnt + 1'b1;
               end
               drive_nx = lit_nx ? {4{RED}} : '0;
            end
         end
         default: state_nx = MONITOR;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= MONITOR;
         samp       <= {4{RED}};
         prev       <= {4{RED}};
         drive      <= {4{RED}};
         ycnt       <= '0;
         filt       <= '0;
         hcnt       <= '0;
         lit        <= 1'b0;
         fault      <= 1'b0;
         fault_code <= '0;
         fault_src  <= '0;
      end else begin
         state      <= state_nx;
         prev       <= samp;
         samp       <= {light_M1, light_M2, light_MT, light_S};
         drive      <= drive_nx;
         ycnt       <= leave ? '0 : ycnt_nx;
         filt       <= filt_nx;
         hcnt       <= hcnt_nx;
         lit        <= lit_nx;
         fault      <= fault_nx;
         fault_code <= code_nx;
         fault_src  <= src_nx;
      end
   end

   assign out_M1 = drive[3];
   assign out_M2 = drive[2];
   assign out_MT = drive[1];
   assign out_S  = drive[0];
endmodule

// File: tb/tb_light_conflict_monitor.sv
// tb/tb_light_conflict_monitor.sv - self-checking bench for light_conflict_monitor
module tb_light_conflict_monitor;
   localparam int MIN_YELLOW      = 30;
   localparam int CONFLICT_FILTER = 2;
   localparam int FLASH_HALF      = 5;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, X3 = 3'b011;
   localparam logic [11:0] ALLR = {R, R, R, R};

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] light_M1 = R, light_M2 = R, light_MT = R, light_S = R;
   logic       clear_fault = 1'b0;
   logic [2:0] out_M1, out_M2, out_MT, out_S;
   logic       fault;
   logic [2:0] fault_code;
   logic [3:0] fault_src;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   light_conflict_monitor #(
      .MIN_YELLOW(MIN_YELLOW), .CONFLICT_FILTER(CONFLICT_FILTER), .FLASH_HALF(FLASH_HALF)
   ) dut (
      .clk(clk), .rst(rst),
      .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
      .clear_fault(clear_fault),
      .out_M1(out_M1), .out_M2(out_M2), .out_MT(out_MT), .out_S(out_S),
      .fault(fault), .fault_code(fault_code), .fault_src(fault_src)
   );

   // Reference model: history of sampled vectors plus the latched fault record.
   logic [11:0] hist[$];
   logic        mfault;
   logic [2:0]  mcode;
   logic [3:0]  msrc;
   logic [11:0] mout;
   int          age;

   function automatic logic [2:0] lp(input logic [11:0] v, input int a);
      return v[11-3*a -: 3];
   endfunction

   function automatic logic is_act(input logic [2:0] c);
      return (c == Y) || (c == G);
   endfunction

   function automatic logic [3:0] conf_set(input logic [11:0] v);
      logic [3:0] s;
      logic any_m;
      s = '0;
      any_m = is_act(lp(v, 0)) || is_act(lp(v, 1)) || is_act(lp(v, 2));
      if (is_act(lp(v, 3)) && any_m) begin
         s[0] = 1'b1;
         for (int a = 0; a < 3; a++) if (is_act(lp(v, a))) s[3-a] = 1'b1;
      end
      if (is_act(lp(v, 1)) && is_act(lp(v, 2))) begin
         s[2] = 1'b1;
         s[1] = 1'b1;
      end
      return s;
   endfunction

   function automatic logic [3:0] inv_set(input logic [11:0] v);
      logic [3:0] s;
      s = '0;
      for (int a = 0; a < 4; a++) s[3-a] = !(lp(v, a) == R || is_act(lp(v, a)));
      return s;
   endfunction

   function automatic logic bad(input logic [11:0] v);
      return (|conf_set(v)) || (|inv_set(v));
   endfunction

   task automatic model_reset();
      hist.delete();
      hist.push_back(ALLR);
      hist.push_back(ALLR);
      mfault = 1'b0; mcode = '0; msrc = '0; mout = ALLR; age = 0;
   endtask

   task automatic model_edge(input logic [11:0] vin, input logic clr);
      logic [11:0] cur, prv;
      logic [3:0]  skp, sht, bsq;
      logic [2:0]  c, p, code;
      logic [3:0]  src;
      int n, run, streak;
      n = hist.size();
      cur = hist[n-1];
      prv = hist[n-2];
      if (!mfault) begin
         skp = '0; sht = '0; bsq = '0;
         for (int a = 0; a < 4; a++) begin
            c = lp(cur, a);
            p = lp(prv, a);
            run = 0;
            for (int k = n - 2; k >= 0 && run < MIN_YELLOW && lp(hist[k], a) == Y; k--) run++;
            skp[3-a] = (p == G) && (c == R);
            sht[3-a] = (p == Y) && (c == R) && (run < MIN_YELLOW);
            bsq[3-a] = ((p == R) && (c == Y)) || ((p == Y) && (c == G));
         end
         streak = 0;
         for (int k = n - 1; k >= 0 && streak < CONFLICT_FILTER && bad(hist[k]); k--) streak++;
         code = 3'd0; src = '0;
         if (bad(cur) && streak >= CONFLICT_FILTER) begin
            code = (|conf_set(cur)) ? 3'd2 : 3'd1;
            src  = (|conf_set(cur)) ? conf_set(cur) : inv_set(cur);
         end else if (|skp) begin code = 3'd3; src = skp; end
         else if (|sht)     begin code = 3'd4; src = sht; end
         else if (|bsq)     begin code = 3'd5; src = bsq; end
         if (code != 3'd0) begin
            mfault = 1'b1; mcode = code; msrc = src; age = 0; mout = ALLR;
         end else begin
            mout = bad(cur) ? ALLR : cur;
         end
      end else if (clr && cur == ALLR) begin
         mfault = 1'b0; mcode = '0; msrc = '0; mout = ALLR;
      end else begin
         age++;
         mout = (((age / FLASH_HALF) % 2) == 0) ? ALLR : 12'h000;
      end
      hist.push_back(vin);
      if (hist.size() > 64) hist.delete(0);
   endtask

   function automatic logic [11:0] dout();
      return {out_M1, out_M2, out_MT, out_S};
   endfunction

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [11:0] v, input logic clr);
      {light_M1, light_M2, light_MT, light_S} = v;
      clear_fault = clr;
      @(posedge clk);
      model_edge(v, clr);
      #1;
      chk("model_out", dout(), mout);
      chk("model_fault", 12'(fault), 12'(mfault));
      chk("model_code", 12'(fault_code), 12'(mcode));
      chk("model_src", 12'(fault_src), 12'(msrc));
   endtask

   task automatic do_reset();
      rst = 1'b0;
      {light_M1, light_M2, light_MT, light_S} = ALLR;
      clear_fault = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_out", dout(), ALLR);
      chk("reset_fault", 12'(fault), 12'd0);
      chk("reset_code", 12'(fault_code), 12'd0);
      chk("reset_src", 12'(fault_src), 12'd0);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic yellow_run(input int n, input logic expect_fault);
      do_reset();
      repeat (2) step({R, R, G, R}, 1'b0);
      repeat (n) step({R, R, Y, R}, 1'b0);
      repeat (2) step(ALLR, 1'b0);
      chk("yellow_fault", 12'(fault), 12'(expect_fault));
      chk("yellow_code", 12'(fault_code), expect_fault ? 12'd4 : 12'd0);
      chk("yellow_src", 12'(fault_src), expect_fault ? 12'b0010 : 12'd0);
   endtask

   typedef struct {
      bit          rst_before;
      logic [11:0] vin;
      logic        clr;
      logic [11:0] eout;
      logic        efault;
      logic [2:0]  ecode;
      logic [3:0]  esrc;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit rb, input logic [11:0] v, input logic c, input logic [11:0] eo,
                      input logic ef, input logic [2:0] ec, input logic [3:0] es);
      vec_t t;
      t.rst_before = rb; t.vin = v; t.clr = c; t.eout = eo;
      t.efault = ef; t.ecode = ec; t.esrc = es;
      tbl.push_back(t);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1);
   end

   initial begin
      logic [11:0] rv, last_in;
      logic [2:0]  c;
      int          hold_red, r;

      // One-cycle conflict is masked, then S falls G->R (skip yellow).
      add(1, {G,R,R,R}, 0, ALLR,      0, 0, 4'b0000);
      add(0, {G,R,R,R}, 0, {G,R,R,R}, 0, 0, 4'b0000);
      add(0, {G,R,R,G}, 0, {G,R,R,R}, 0, 0, 4'b0000);
      add(0, {G,R,R,R}, 0, ALLR,      0, 0, 4'b0000);
      add(0, {G,R,R,R}, 0, ALLR,      1, 3, 4'b0001);
      // Two-cycle conflict faults, flashes 5 on / 5 off, clear only with all red.
      add(1, {G,R,R,R}, 0, ALLR,      0, 0, 4'b0000);
      add(0, {G,R,R,G}, 0, {G,R,R,R}, 0, 0, 4'b0000);
      add(0, {G,R,R,G}, 0, ALLR,      0, 0, 4'b0000);
      add(0, {G,R,R,G}, 0, ALLR,      1, 2, 4'b1001);
      for (int i = 0; i < 4; i++) add(0, ALLR, 0, ALLR,   1, 2, 4'b1001);
      for (int i = 0; i < 5; i++) add(0, ALLR, 0, 12'h000, 1, 2, 4'b1001);
      add(0, ALLR,      0, ALLR, 1, 2, 4'b1001);
      add(0, {Y,R,R,R}, 0, ALLR, 1, 2, 4'b1001);
      add(0, {Y,R,R,R}, 1, ALLR, 1, 2, 4'b1001);
      add(0, ALLR,      0, ALLR, 1, 2, 4'b1001);
      add(0, ALLR,      1, ALLR, 0, 0, 4'b0000);
      add(0, ALLR,      0, ALLR, 0, 0, 4'b0000);
      // Invalid code together with a conflict: conflict wins.
      add(1, {G,R,X3,G}, 0, ALLR, 0, 0, 4'b0000);
      add(0, {G,R,X3,G}, 0, ALLR, 0, 0, 4'b0000);
      add(0, {G,R,X3,G}, 0, ALLR, 1, 2, 4'b1001);

      model_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_before) do_reset();
         step(tbl[i].vin, tbl[i].clr);
         chk("tbl_out", dout(), tbl[i].eout);
         chk("tbl_fault", 12'(fault), 12'(tbl[i].efault));
         chk("tbl_code", 12'(fault_code), 12'(tbl[i].ecode));
         chk("tbl_src", 12'(fault_src), 12'(tbl[i].esrc));
      end

      // Asynchronous reset during the dark half of the flash.
      repeat (5) step(ALLR, 1'b0);
      chk("dark_before_reset", dout(), 12'h000);
      #1 rst = 1'b0;
      #1;
      chk("async_out", dout(), ALLR);
      chk("async_fault", 12'(fault), 12'd0);
      chk("async_code", 12'(fault_code), 12'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b1;

      // Legal cycle: outputs mirror the inputs with no fault.
      do_reset();
      last_in = ALLR;
      for (int i = 0; i < 40; i++) begin
         rv = (i < 4) ? {G,G,R,R} : (i < 34) ? {Y,Y,R,R} : (i < 36) ? ALLR : {R,R,R,G};
         step(rv, 1'b0);
         chk("mirror", dout(), last_in);
         last_in = rv;
      end
      chk("legal_fault", 12'(fault), 12'd0);

      yellow_run(MIN_YELLOW - 1, 1'b1);
      yellow_run(MIN_YELLOW, 1'b0);

      // Randomised traffic against the reference model.
      do_reset();
      rv = ALLR;
      hold_red = 0;
      for (int s = 0; s < 2500; s++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
            rv = ALLR;
         end
         if ($urandom_range(0, 59) == 0) hold_red = 6;
         if (hold_red > 0) begin
            rv = ALLR;
            hold_red--;
         end else begin
            for (int a = 0; a < 4; a++) begin
               c = rv[11-3*a -: 3];
               if ($urandom_range(0, (c == Y) ? 30 : 7) == 0) begin
                  r = int'($urandom_range(0, 99));
                  if (r < 3)       c = 3'($urandom);
                  else if (r < 80) c = (c == R) ? G : (c == G) ? Y : R;
                  else             c = (r % 3 == 0) ? R : (r % 3 == 1) ? Y : G;
               end
               rv[11-3*a -: 3] = c;
            end
         end
         step(rv, $urandom_range(0, 2) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
